// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and helpers shared by the GPIO port
package gpio_pkg;
    localparam int REGADR_W = 3;
    localparam logic [REGADR_W-1:0] GPIO_DATA   = 3'd0;
    localparam logic [REGADR_W-1:0] GPIO_OE     = 3'd1;
    localparam logic [REGADR_W-1:0] GPIO_STATUS = 3'd2;
    localparam logic [REGADR_W-1:0] GPIO_MASK   = 3'd3;
    localparam logic [REGADR_W-1:0] GPIO_EDGE   = 3'd4;
    localparam logic [REGADR_W-1:0] GPIO_BOTH   = 3'd5;
    localparam logic [REGADR_W-1:0] GPIO_SET    = 3'd6;
    localparam logic [REGADR_W-1:0] GPIO_CLR    = 3'd7;
    function automatic int arm_cycles(input int nsync, input int deb);
        return nsync + deb + 1;
    endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one-bit filter, output follows input only after DEB_CYC consecutive disagreeing cycles
module gpio_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEB_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
        if (rst) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (d == q)
            cnt <= '0;
        else if (cnt == CW'(DEB_CYC - 1)) begin
            cnt <= '0;
            q   <= d;
        end else
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/gpio_port.sv
// gpio_port: parametrised GPIO with set/clear writes, filtered inputs, edge capture and masked irq
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NSYNC   = 2,
    parameter int DEB_CYC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                wr,
    input  logic [REGADR_W-1:0] regadr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [WIDTH-1:0]    gp_in,
    output logic [WIDTH-1:0]    gp_out,
    output logic [WIDTH-1:0]    gp_oe,
    output logic                irq
);
    localparam int ARM_N = arm_cycles(NSYNC, DEB_CYC);
    localparam int AW    = $clog2(ARM_N + 1);
    logic [NSYNC-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0] pin_f, prev, out_r, oe_r, status, mask, edge_sel, both;
    logic [WIDTH-1:0] wd, ev, w1c, status_nx, mask_nx, out_nx, rsel;
    logic [AW-1:0]    arm_cnt;
    logic             armed, we, unused_wdata;
    assign we           = sel & wr;
    assign wd           = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;
    assign gp_out       = out_r;
    assign gp_oe        = oe_r;
    assign rdata        = sel ? 32'(rsel) : 32'd0;
    always_ff @(posedge clk)
        sync <= rst ? '0 : {sync[NSYNC-2:0], gp_in};
    if (DEB_CYC == 0) begin : g_bypass
        assign pin_f = sync[NSYNC-1];
    end else begin : g_deb
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            gpio_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
                .clk(clk),
                .rst(rst),
                .d  (sync[NSYNC-1][i]),
                .q  (pin_f[i])
            );
        end
    end
    // events are held off until the input pipeline has settled after reset
    always_comb begin
        ev        = armed ? ((pin_f & ~prev & ~edge_sel) | (~pin_f & prev & edge_sel) | (both & (pin_f ^ prev))) : '0;
        w1c       = (we && regadr == GPIO_STATUS) ? wd : '0;
        status_nx = (status & ~w1c) | ev;
        mask_nx   = (we && regadr == GPIO_MASK) ? wd : mask;
        out_nx    = !we                  ? out_r :
                    regadr == GPIO_DATA  ? wd :
                    regadr == GPIO_SET   ? (out_r | wd) :
                    regadr == GPIO_CLR   ? (out_r & ~wd) : out_r;
        rsel      = regadr == GPIO_DATA   ? pin_f :
                    regadr == GPIO_OE     ? oe_r :
                    regadr == GPIO_STATUS ? status :
                    regadr == GPIO_MASK   ? mask :
                    regadr == GPIO_EDGE   ? edge_sel :
                    regadr == GPIO_BOTH   ? both : '0;
    end
    always_ff @(posedge clk)
        if (rst) begin
            out_r    <= '0;
            oe_r     <= '0;
            status   <= '0;
            mask     <= '0;
            edge_sel <= '0;
            both     <= '0;
            prev     <= '0;
            irq      <= 1'b0;
            arm_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            out_r    <= out_nx;
            oe_r     <= (we && regadr == GPIO_OE) ? wd : oe_r;
            status   <= status_nx;
            mask     <= mask_nx;
            edge_sel <= (we && regadr == GPIO_EDGE) ? wd : edge_sel;
            both     <= (we && regadr == GPIO_BOTH) ? wd : both;
            prev     <= pin_f;
            irq      <= |(status_nx & mask_nx);
            if (!armed) begin
                if (arm_cnt == AW'(ARM_N - 1))
                    armed <= 1'b1;
                else
                    arm_cnt <= arm_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed vector table plus multi-cycle sequences for two gpio_port instances
module tb_gpio_port;
    logic        clk, rst, sel, wr;
    logic [2:0]  regadr;
    logic [31:0] wdata, rdata, rdata4;
    logic [7:0]  gin, gin4, gout, gout4, goe, goe4;
    logic        irq, irq4;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic        sel, wr;
        logic [2:0]  adr;
        logic [31:0] wd, exp_rd;
        logic [7:0]  exp_out, exp_oe;
    } vec_t;
    vec_t vt[14];

    gpio_port dut (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .regadr(regadr), .wdata(wdata),
        .rdata(rdata), .gp_in(gin), .gp_out(gout), .gp_oe(goe), .irq(irq)
    );
    gpio_port #(.DEB_CYC(4)) dut4 (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .regadr(regadr), .wdata(wdata),
        .rdata(rdata4), .gp_in(gin4), .gp_out(gout4), .gp_oe(goe4), .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr_reg(input logic [2:0] adr, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; regadr = adr; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic chk_rd(input string name, input bit which, input logic [2:0] adr, input logic [31:0] exp);
        sel = 1'b1; wr = 1'b0; regadr = adr;
        #1;
        chk(name, which ? rdata4 : rdata, exp);
        sel = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1, 1, 3'd1, 32'h0000_000F, 32'h00, 8'h00, 8'h00};
        vt[1]  = '{1, 1, 3'd0, 32'h0000_00A5, 32'hFF, 8'h00, 8'h0F};
        vt[2]  = '{1, 1, 3'd6, 32'h0000_0040, 32'h00, 8'hA5, 8'h0F};
        vt[3]  = '{1, 1, 3'd7, 32'h0000_0001, 32'h00, 8'hE5, 8'h0F};
        vt[4]  = '{1, 0, 3'd1, 32'h0000_0000, 32'h0F, 8'hE4, 8'h0F};
        vt[5]  = '{1, 0, 3'd0, 32'h0000_0000, 32'hFF, 8'hE4, 8'h0F};
        vt[6]  = '{0, 0, 3'd1, 32'h0000_0000, 32'h00, 8'hE4, 8'h0F};
        vt[7]  = '{1, 0, 3'd3, 32'h0000_0000, 32'h00, 8'hE4, 8'h0F};
        vt[8]  = '{1, 1, 3'd4, 32'hFFFF_FFAA, 32'h00, 8'hE4, 8'h0F};
        vt[9]  = '{1, 0, 3'd4, 32'h0000_0000, 32'hAA, 8'hE4, 8'h0F};
        vt[10] = '{1, 1, 3'd4, 32'h0000_0000, 32'hAA, 8'hE4, 8'h0F};
        vt[11] = '{1, 1, 3'd1, 32'h0000_0000, 32'h0F, 8'hE4, 8'h0F};
        vt[12] = '{1, 0, 3'd1, 32'h0000_0000, 32'h00, 8'hE4, 8'h00};
        vt[13] = '{1, 0, 3'd0, 32'h0000_0000, 32'hFF, 8'hE4, 8'h00};

        rst = 1'b1; sel = 1'b0; wr = 1'b0; regadr = '0; wdata = '0;
        gin = 8'hFF; gin4 = 8'hFF;
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk_rd("t1 status", 0, 3'd2, 32'h0);
        chk_rd("t1 status4", 1, 3'd2, 32'h0);
        chk("t1 irq", irq, 0);
        chk("t1 irq4", irq4, 0);
        chk("t1 oe", goe, 8'h00);
        chk_rd("t1 data", 0, 3'd0, 32'hFF);
        chk_rd("t1 data4", 1, 3'd0, 32'hFF);

        for (int i = 0; i < 14; i++) begin
            sel = vt[i].sel; wr = vt[i].wr; regadr = vt[i].adr; wdata = vt[i].wd;
            #1;
            chk($sformatf("vec%0d rdata", i), rdata, vt[i].exp_rd);
            chk($sformatf("vec%0d gp_out", i), gout, vt[i].exp_out);
            chk($sformatf("vec%0d gp_oe", i), goe, vt[i].exp_oe);
            tick();
            sel = 1'b0; wr = 1'b0; wdata = '0;
        end

        gin = 8'h00; gin4 = 8'h00;
        tick(8);
        chk_rd("falls ignored", 0, 3'd2, 32'h0);

        wr_reg(3'd3, 32'h1);
        wr_reg(3'd2, 32'hFF);
        gin[0] = 1'b1;
        tick(2);
        chk_rd("t3 status early", 0, 3'd2, 32'h0);
        chk("t3 irq early", irq, 0);
        tick();
        chk_rd("t3 status", 0, 3'd2, 32'h1);
        chk("t3 irq", irq, 1);
        wr_reg(3'd2, 32'h1);
        chk("t3 irq cleared", irq, 0);
        chk_rd("t3 status cleared", 0, 3'd2, 32'h0);

        wr_reg(3'd5, 32'h08);
        wr_reg(3'd3, 32'h09);
        gin[3] = 1'b1;
        tick(3);
        chk_rd("t4 rise", 0, 3'd2, 32'h08);
        wr_reg(3'd2, 32'h08);
        chk_rd("t4 rise cleared", 0, 3'd2, 32'h0);
        tick();
        gin[3] = 1'b0;
        tick(2);
        chk_rd("t4 pin low", 0, 3'd0, 32'h01);
        wr_reg(3'd2, 32'h08);
        chk_rd("t4 fall wins w1c", 0, 3'd2, 32'h08);
        chk("t4 irq", irq, 1);
        wr_reg(3'd2, 32'h08);
        chk_rd("t4 cleared", 0, 3'd2, 32'h0);

        wr_reg(3'd3, 32'h04);
        wr_reg(3'd2, 32'hFF);
        chk_rd("t5 status4 start", 1, 3'd2, 32'h0);
        gin4[2] = 1'b1;
        tick(3);
        gin4[2] = 1'b0;
        tick(10);
        chk_rd("t5 glitch data4", 1, 3'd0, 32'h0);
        chk_rd("t5 glitch status4", 1, 3'd2, 32'h0);
        gin4[2] = 1'b1;
        tick(5);
        chk_rd("t5 data4 before", 1, 3'd0, 32'h0);
        tick();
        chk_rd("t5 data4 after", 1, 3'd0, 32'h04);
        tick();
        chk_rd("t5 status4", 1, 3'd2, 32'h04);
        chk("t5 irq4", irq4, 1);

        gin4 = 8'h01;
        tick(3);
        chk("t6 irq4 before rst", irq4, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 irq4", irq4, 0);
        chk("t6 irq", irq, 0);
        chk("t6 gp_out", gout, 8'h00);
        chk("t6 gp_oe", goe, 8'h00);
        chk_rd("t6 mask", 0, 3'd3, 32'h0);
        chk_rd("t6 both", 0, 3'd5, 32'h0);
        chk_rd("t6 status4", 1, 3'd2, 32'h0);
        tick(10);
        chk_rd("t6 no spurious", 0, 3'd2, 32'h0);
        chk_rd("t6 no spurious4", 1, 3'd2, 32'h0);
        chk_rd("t6 data", 0, 3'd0, 32'h01);
        chk_rd("t6 data4", 1, 3'd0, 32'h01);
        gin[1] = 1'b1;
        tick(3);
        chk_rd("t6 armed event", 0, 3'd2, 32'h02);
        chk("t6 irq masked", irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
